// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter with internal baud divider, runtime parity,
// 1/2 stop bits, valid/ready input and a one-entry holding register that lets
// frames run back to back with no idle bit between them.
module uart_tx_core #(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DIV_WIDTH-1:0]  Baud_Div,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   input  logic [DATA_WIDTH-1:0] TX_DATA,
   input  logic                  TX_VALID,
   output logic                  TX_READY,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int BIT_W = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state_r;
   logic                  busy_r;
   logic [DIV_WIDTH-1:0]  tick_r;
   logic [BIT_W-1:0]      bit_r;
   logic [DATA_WIDTH-1:0] shift_r;
   logic                  parity_r;
   logic [DIV_WIDTH-1:0]  div_l;
   logic                  par_en_l;
   logic                  stop2_l;
   logic                  hold_full_r;
   logic [DATA_WIDTH-1:0] hold_data_r;
   logic                  tx_out_r;

   logic                  accept_s;
   logic                  bit_end_s;
   logic                  last_stop_s;
   logic                  load_s;
   logic                  line_s;

   // Even parity is the XOR of the payload; odd parity is its inverse.
   function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

   assign TX_READY    = ~hold_full_r & RST;
   assign accept_s    = TX_VALID & TX_READY;
   assign bit_end_s   = (tick_r == (div_l - DIV_WIDTH'(1)));
   assign last_stop_s = (bit_r == BIT_W'(stop2_l));
   // A held word starts a frame either from idle or right at the end of the last stop bit.
   assign load_s      = hold_full_r &
                        ((state_r == IDLE) | ((state_r == STOP) & bit_end_s & last_stop_s));
   assign TX_OUT      = tx_out_r;
   assign Busy        = busy_r;

   // Line level implied by the current state; registered one cycle later into TX_OUT.
   always_comb begin
      line_s = 1'b1;
      case (state_r)
         IDLE:    line_s = 1'b1;
         START:   line_s = 1'b0;
         DATA:    line_s = shift_r[0];
         PARITY:  line_s = parity_r;
         STOP:    line_s = 1'b1;
         default: line_s = 1'b1;
      endcase
   end

   // Holding register: filled on handshake, emptied when its word moves to the shifter.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         hold_full_r <= 1'b0;
         hold_data_r <= '0;
      end else if (accept_s) begin
         hold_full_r <= 1'b1;
         hold_data_r <= TX_DATA;
      end else if (load_s) begin
         hold_full_r <= 1'b0;
      end
   end

   // Frame sequencer: bit timing, shifting, and per-frame configuration latch.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_r  <= IDLE;
         busy_r   <= 1'b0;
         tick_r   <= '0;
         bit_r    <= '0;
         shift_r  <= '0;
         parity_r <= 1'b0;
         div_l    <= DIV_WIDTH'(1);
         par_en_l <= 1'b0;
         stop2_l  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               busy_r <= 1'b0;
            end
            START: begin
               if (bit_end_s) begin
                  tick_r  <= '0;
                  bit_r   <= '0;
                  state_r <= DATA;
               end else begin
                  tick_r <= tick_r + DIV_WIDTH'(1);
               end
            end
            DATA: begin
               if (bit_end_s) begin
                  tick_r  <= '0;
                  shift_r <= shift_r >> 1;
                  if (bit_r == BIT_W'(DATA_WIDTH - 1)) begin
                     bit_r   <= '0;
                     state_r <= par_en_l ? PARITY : STOP;
                  end else begin
                     bit_r <= bit_r + BIT_W'(1);
                  end
               end else begin
                  tick_r <= tick_r + DIV_WIDTH'(1);
               end
            end
            PARITY: begin
               if (bit_end_s) begin
                  tick_r  <= '0;
                  bit_r   <= '0;
                  state_r <= STOP;
               end else begin
                  tick_r <= tick_r + DIV_WIDTH'(1);
               end
            end
            STOP: begin
               if (bit_end_s) begin
                  tick_r <= '0;
                  if (last_stop_s) begin
                     bit_r   <= '0;
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                  end else begin
                     bit_r <= bit_r + BIT_W'(1);
                  end
               end else begin
                  tick_r <= tick_r + DIV_WIDTH'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
         // Frame start overrides the per-state update above.
         if (load_s) begin
            state_r  <= START;
            busy_r   <= 1'b1;
            tick_r   <= '0;
            bit_r    <= '0;
            shift_r  <= hold_data_r;
            parity_r <= calc_parity(hold_data_r, PAR_TYP);
            div_l    <= (Baud_Div == '0) ? DIV_WIDTH'(1) : Baud_Div;
            par_en_l <= PAR_EN;
            stop2_l  <= STOP2;
         end
      end
   end

   // Registered serial line; reset forces the idle level.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         tx_out_r <= 1'b1;
      end else begin
         tx_out_r <= line_s;
      end
   end

endmodule

// File: tb/tb_uart_tx_core.sv
// Testbench for uart_tx_core: directed scenarios plus randomized single and
// back-to-back frames, checked cycle by cycle against a bit-list model.
module tb_uart_tx_core;

   logic        CLK = 1'b0;
   logic        RST;
   logic [15:0] Baud_Div;
   logic        PAR_EN;
   logic        PAR_TYP;
   logic        STOP2;
   logic [7:0]  TX_DATA;
   logic        TX_VALID;
   logic        TX_READY;
   logic        TX_OUT;
   logic        Busy;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   // Expected serial waveform: one entry per clock, frames concatenated.
   bit bits_q[$];
   int idx;

   uart_tx_core #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
      .CLK(CLK), .RST(RST), .Baud_Div(Baud_Div), .PAR_EN(PAR_EN),
      .PAR_TYP(PAR_TYP), .STOP2(STOP2), .TX_DATA(TX_DATA),
      .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TX_OUT(TX_OUT), .Busy(Busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Append one frame to the model: each bit held for max(div,1) cycles.
   task automatic add_frame(input logic [7:0] d, input int div, input bit pe, input bit pt, input bit s2);
      bit fb[$];
      int n;
      n = (div == 0) ? 1 : div;
      fb.push_back(1'b0);
      for (int i = 0; i < 8; i++) fb.push_back(d[i]);
      if (pe) fb.push_back((($countones(d) % 2) == 1) ^ pt);
      fb.push_back(1'b1);
      if (s2) fb.push_back(1'b1);
      foreach (fb[k]) repeat (n) bits_q.push_back(fb[k]);
   endtask

   // Index j is the sample taken after edge E(j+1), E0 being the accepting edge.
   function automatic logic exp_line(input int j);
      if (j >= 1 && (j - 1) < bits_q.size()) return bits_q[j-1];
      return 1'b1;
   endfunction

   function automatic logic exp_busy(input int j);
      return (j < bits_q.size());
   endfunction

   task automatic tick_check();
      @(posedge CLK); #1;
      chk("tx_out", TX_OUT, exp_line(idx));
      chk("busy", Busy, exp_busy(idx));
      idx++;
   endtask

   task automatic run_to_end();
      while (idx < bits_q.size() + 3) tick_check();
   endtask

   // Present one word to an idle core and step through its accepting edge.
   task automatic send_first(input logic [7:0] d, input int div, input bit pe, input bit pt, input bit s2);
      TX_DATA  = d;
      Baud_Div = 16'(div);
      PAR_EN   = pe;
      PAR_TYP  = pt;
      STOP2    = s2;
      TX_VALID = 1'b1;
      chk("ready_idle", TX_READY, 1'b1);
      @(posedge CLK); #1;
      TX_VALID = 1'b0;
      chk("ready_drop", TX_READY, 1'b0);
      chk("idle_line", TX_OUT, 1'b1);
      chk("idle_busy", Busy, 1'b0);
      bits_q.delete();
      add_frame(d, div, pe, pt, s2);
      idx = 0;
   endtask

   initial begin
      RST = 1'b0; TX_VALID = 1'b0; TX_DATA = 8'h00;
      Baud_Div = 16'd4; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_tx_out", TX_OUT, 1'b1);
      chk("rst_busy", Busy, 1'b0);
      chk("rst_ready", TX_READY, 1'b0);
      RST = 1'b1;
      #1;
      chk("ready_after_rst", TX_READY, 1'b1);

      // 0xA5, div 4, no parity, one stop: 40-cycle frame
      send_first(8'hA5, 4, 1'b0, 1'b0, 1'b0);
      chk("len_plain", bits_q.size(), 40);
      run_to_end();

      // parity variants
      send_first(8'hA5, 4, 1'b1, 1'b0, 1'b0);
      chk("len_parity", bits_q.size(), 44);
      run_to_end();
      send_first(8'hA5, 4, 1'b1, 1'b1, 1'b0);
      run_to_end();
      send_first(8'h07, 4, 1'b1, 1'b0, 1'b0);
      run_to_end();

      // back-to-back with TX_VALID held high
      TX_DATA = 8'h55; Baud_Div = 16'd2; PAR_EN = 1'b0; STOP2 = 1'b0; TX_VALID = 1'b1;
      @(posedge CLK); #1;
      TX_DATA = 8'h0F;
      chk("b2b_ready_drop", TX_READY, 1'b0);
      bits_q.delete();
      add_frame(8'h55, 2, 1'b0, 1'b0, 1'b0);
      add_frame(8'h0F, 2, 1'b0, 1'b0, 1'b0);
      idx = 0;
      tick_check();
      chk("b2b_ready_reassert", TX_READY, 1'b1);
      tick_check();
      TX_VALID = 1'b0;
      chk("b2b_ready_held", TX_READY, 1'b0);
      run_to_end();

      // div 0 with two stop bits, divider changed mid-frame for the next word
      send_first(8'hFF, 0, 1'b0, 1'b0, 1'b1);
      chk("len_div0", bits_q.size(), 11);
      tick_check();
      Baud_Div = 16'd8; TX_DATA = 8'h3C; TX_VALID = 1'b1;
      tick_check();
      TX_VALID = 1'b0;
      add_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
      run_to_end();

      // holding full: 0x22 refused until 0x11 starts
      send_first(8'h33, 2, 1'b0, 1'b0, 1'b0);
      tick_check();
      TX_DATA = 8'h11; TX_VALID = 1'b1;
      tick_check();
      add_frame(8'h11, 2, 1'b0, 1'b0, 1'b0);
      TX_DATA = 8'h22;
      while (idx < 21) begin
         chk("hold_refuse", TX_READY, 1'b0);
         tick_check();
      end
      chk("hold_free", TX_READY, 1'b1);
      tick_check();
      TX_VALID = 1'b0;
      add_frame(8'h22, 2, 1'b0, 1'b0, 1'b0);
      run_to_end();

      // reset during data bit 3 discards frame and held word
      send_first(8'hC3, 4, 1'b0, 1'b0, 1'b0);
      tick_check();
      TX_DATA = 8'h5A; TX_VALID = 1'b1;
      tick_check();
      TX_VALID = 1'b0;
      while (idx < 18) tick_check();
      RST = 1'b0;
      #1;
      chk("rst_mid_ready", TX_READY, 1'b0);
      @(posedge CLK); #1;
      chk("rst_mid_line", TX_OUT, 1'b1);
      chk("rst_mid_busy", Busy, 1'b0);
      chk("rst_mid_ready2", TX_READY, 1'b0);
      RST = 1'b1;
      #1;
      chk("rst_mid_ready_after", TX_READY, 1'b1);
      repeat (60) begin
         @(posedge CLK); #1;
         chk("post_rst_line", TX_OUT, 1'b1);
         chk("post_rst_busy", Busy, 1'b0);
      end

      // randomized single frames and back-to-back pairs with config changes
      for (int r = 0; r < 30; r++) begin
         logic [7:0] d1, d2;
         int dv1, dv2, w;
         bit pe1, pt1, s21, pe2, pt2, s22, pair;
         d1 = 8'($urandom); d2 = 8'($urandom);
         dv1 = $urandom_range(0, 4); dv2 = $urandom_range(0, 4);
         pe1 = 1'($urandom); pt1 = 1'($urandom); s21 = 1'($urandom);
         pe2 = 1'($urandom); pt2 = 1'($urandom); s22 = 1'($urandom);
         pair = 1'($urandom);
         send_first(d1, dv1, pe1, pt1, s21);
         if (pair) begin
            w = $urandom_range(0, bits_q.size() - 2);
            repeat (w + 1) tick_check();
            TX_DATA = d2; Baud_Div = 16'(dv2); PAR_EN = pe2; PAR_TYP = pt2; STOP2 = s22;
            TX_VALID = 1'b1;
            tick_check();
            TX_VALID = 1'b0;
            add_frame(d2, dv2, pe2, pt2, s22);
         end
         run_to_end();
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Single-clock, parametrised UART transmitter for the next UART generation. It replaces the fixed-prescale TX path with several runtime options: an internal baud divider, runtime parity mode, 1 or 2 stop bits, a valid/ready input handshake, and a one-entry holding register that allows gap-free back-to-back frames. It sits between the TX data source (FIFO or register file) and the serial line.

Parameters:
DATA_WIDTH, 8, payload bits per frame (5..9 supported)
DIV_WIDTH, 16, width of Baud_Div (clock cycles per serial bit)

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous, active-low reset
Baud_Div  input  DIV_WIDTH  clock cycles per bit; 0 is treated as 1
PAR_EN  input  1  1 = append parity bit
PAR_TYP  input  1  0 = even, 1 = odd
STOP2  input  1  1 = two stop bits, 0 = one
TX_DATA  input  DATA_WIDTH  word to send
TX_VALID  input  1  TX_DATA is valid
TX_READY  output  1  holding register empty; word accepted on TX_VALID & TX_READY
TX_OUT  output  1  serial line, idle high, LSB first
Busy  output  1  frame in progress

Behaviour:
- Reset: single clock, synchronous active-low RST; reset has priority over every other input.
- Reset values: TX_OUT = 1, Busy = 0, state = IDLE, holding register empty, bit/tick counters = 0.
- TX_READY = holding-empty AND RST high, so it is 0 while RST = 0.
- Handshake: at a rising edge with TX_VALID & TX_READY, TX_DATA is copied into the holding register. TX_READY drops the next cycle. TX_DATA is don't-care otherwise.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when the holding register is full, go to START at the next edge.
  - On the START transition: move the holding word to the shift register, clear the holding register, and latch Baud_Div, PAR_EN, PAR_TYP and STOP2.
  - Config changes mid-frame have no effect until the next frame start.
- Timing: TX_OUT is registered. Its start bit (0) appears at the second rising edge after the accepting edge, i.e. 2 cycles of latency from an idle core.
- Bit timing: every bit lasts exactly max(Baud_Div,1) cycles, counted by a tick counter that reloads at each bit boundary.
- Bit sequence:
  - START: one bit of 0.
  - DATA: DATA_WIDTH bits, LSB first.
  - PARITY: present only if the latched PAR_EN = 1. Even mode sends XOR of the data; odd mode sends its inverse.
  - STOP: one bit of 1, or two if the latched STOP2 = 1.
- Frame length = Div × (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) cycles.
- End of the last stop bit:
  - If the holding register is full, go directly to START with no idle cycle. The new start bit immediately follows the stop bit, and new config is latched there.
  - Otherwise go to IDLE; TX_OUT stays 1.
- Busy is 1 in every state except IDLE and is registered alongside the state.
- A new word may be accepted while a frame is in progress: TX_READY is high whenever the holding register is empty. This gives at most one word in flight plus one held.
- Simultaneous events:
  - Acceptance in the same cycle that the FSM empties the holding register is legal. The holding register ends full with the new word, and the old word goes to the shifter.
  - TX_VALID held high with TX_READY low causes no action.
- Reset mid-frame: the line returns to 1 at the next edge, and both the frame and the held word are discarded.

Test Plan:
1. DATA_WIDTH = 8, Baud_Div = 4, PAR_EN = 0, STOP2 = 0, send 0xA5 → TX_OUT = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; Busy high for exactly 40 cycles; start bit 2 cycles after the accept edge.
2. Same setup with PAR_EN = 1 → for 0xA5 (four 1s), PAR_TYP = 0 gives parity bit 0 and PAR_TYP = 1 gives 1; frame is 44 cycles. For 0x07, even mode gives parity 1.
3. Back-to-back: hold TX_VALID, send 0x55 then 0x0F with Baud_Div = 2 → second start bit begins the cycle after the first stop bit ends with no idle high; TX_READY re-asserts at the first frame start; Busy never drops between the frames.
4. Baud_Div = 0 with STOP2 = 1 → every bit is 1 cycle; 0xFF frame is 11 cycles ending with two 1s. Changing Baud_Div to 8 mid-frame leaves the current frame unchanged and the next frame uses 8.
5. Holding full: accept 0x11 and 0x22 during a 0x33 frame → 0x22 is refused until 0x11 starts; output order is 0x33, 0x11, 0x22.
6. Drive RST = 0 for 1 cycle during DATA bit 3 → the next edge shows TX_OUT = 1, Busy = 0, TX_READY = 0 during reset and 1 after; the held word is not transmitted.
